// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and legal WIDTH range for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder reused for every bit position
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit pair per clock LSB first, carry held in a register
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    carry  <= cin;
                    sum_sr <= '0;
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    // hold the counter at the last bit so it never wraps
                    cnt    <= (cnt == LAST) ? cnt : cnt + 1'b1;
                    state  <= (cnt == LAST) ? DONE : SHIFT;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sr;
    assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench with directed and random operations against a + b + cin
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         rnd_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W + 1)'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int t = 0;
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(x, y, c));
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            step();
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    logic       hold = 1'b0;
    logic [W:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold && out_valid) chk("held_stable", 64'({cout, sum}), 64'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
                else chk("result", 64'({cout, sum}), 64'(sb.pop_front()));
            end
            hold = out_valid && !out_ready;
            held = {cout, sum};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int k;
        rst = 1'b1;
        repeat (2) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        step();

        out_ready = 1'b1;
        issue(8'hFF, 8'h01, 1'b0);
        k = 0;
        while (k < 20) begin
            step();
            k++;
            if (out_valid) break;
        end
        chk("latency", 64'(k), 64'd8);
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        step();
        chk("in_ready_return", 64'(in_ready), 64'd1);
        drain(50);

        issue(8'hA5, 8'h5A, 1'b1);
        drain(50);
        issue(8'h00, 8'h00, 1'b1);
        drain(50);

        out_ready = 1'b0;
        issue(8'h3C, 8'h0F, 1'b0);
        a = 8'hFF;
        b = 8'hFF;
        in_valid = 1'b1;
        chk("busy_shift", 64'(busy), 64'd1);
        chk("in_ready_shift", 64'(in_ready), 64'd0);
        k = 0;
        while (!out_valid && k < 50) begin
            step();
            k++;
        end
        repeat (5) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_sum", 64'(sum), 64'h4B);
            chk("bp_cout", 64'(cout), 64'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);
        repeat (20) step();
        chk("no_second_result", 64'(out_valid), 64'd0);

        issue(8'h55, 8'hAA, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum", 64'({cout, sum}), 64'd0);
        sb.delete();
        rst = 1'b0;
        step();
        issue(8'h80, 8'h80, 1'b0);
        drain(50);

        rnd_ready = 1'b1;
        repeat (500) begin
            repeat ($urandom_range(0, 2)) step();
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(500);
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
